scale_ratio_bilinear: RTL
=========================

// Module: scale_ratio_bilinear
// PURPOSE
//  Streaming bilinear downscaler with a runtime ratio 2^NUM_LOG2 : r_den.
//  Generalises the fixed 4:5 scaler: same raster-in/raster-out pixel stream.
//  Sits between the capture pipeline and downstream luma consumers.
//  Uses a 2x2 SlidingWindow instance as its line buffer.
//  Adds round-to-nearest, frame-synchronous ratio latching and a 1:1 passthrough case.
// PARAMETERS
//  LUMA_BITS        8    pixel width
//  MAX_INPUT_WIDTH  640  max row length; sizes the SlidingWindow line buffer
//  COORD_BITS       11   width of every x/y coordinate and of r_width
//  NUM_LOG2         2    NUM = 2^NUM_LOG2 output samples per r_den input samples
//  DEN_BITS         4    width of r_den; must hold 2*NUM
// PORTS
//  clk        in   1           clock, all flops rising edge
//  reset      in   1           asynchronous, active-low reset
//  r_width    in   COORD_BITS  input row length; static within a frame
//  r_den      in   DEN_BITS    ratio denominator; legal range NUM..2*NUM
//  in_pixel   in   LUMA_BITS   input luma
//  in_valid   in   1           in_pixel/in_x/in_y valid this cycle
//  in_x       in   COORD_BITS  input column
//  in_y       in   COORD_BITS  input row
//  out_pixel  out  LUMA_BITS   scaled luma
//  out_valid  out  1           output qualifier, single-cycle pulses
//  out_x      out  COORD_BITS  output column
//  out_y      out  COORD_BITS  output row
// BEHAVIOUR
//  - Reset (reset=0, async): out_valid=0, out_pixel=0, out_x=0, out_y=0.
//    Pipeline valids are cleared and synced=0.
//    While synced=0, pixels are ignored until in_x==0 && in_y==0 arrives.
//  - Frame start (in_valid, in_x==0, in_y==0): latch r_den into den_q and set synced=1.
//    r_den changes mid-frame take effect only at the next frame start.
//  - Per-axis phase d: signed, NUM_LOG2+3 bits; range -NUM < d <= 2*NUM.
//    At axis index 0: d = 0. Otherwise: d = d_prev - NUM.
//    If d <= 0, the axis emits at this index and d_prev <= d + den_q. Otherwise d_prev <= d.
//    Weights: w_left = -d, w_right = NUM + d. Each weight is in 0..NUM, and w_left + w_right = NUM.
//  - Horizontal phase updates on every accepted pixel.
//    Vertical phase updates when in_x==0.
//  - A pixel is emitted iff both axes emit.
//  - Window: [0][*] is the previous row, [*][0] is the previous column.
//    weight[j][i] = wv[j] * wh[i], which is at most NUM^2.
//  - A zero weight forces a zero product regardless of window contents, including X.
//    This covers the stale column-0 data and the first row.
//  - Sum: 4 products, width LUMA_BITS + 2*NUM_LOG2 + 2 bits.
//    out = (sum + 2^(2*NUM_LOG2-1)) >> (2*NUM_LOG2), saturated to all-ones.
//  - Pipeline (4 stages, no backpressure):
//    S1 window + phase; S2 weight products; S3 multiply; S4 sum/round.
//    out_valid rises exactly 4 cycles after the in_valid of the emitting pixel.
//    Stages advance only on their own valid, like the existing scaler.
//  - Output coordinates:
//    out_x = 0 on the first emitted pixel of a row, then +1 per emitted pixel.
//    out_y = 0 on the first emitted row of a frame, then +1 per emitted row.
//    Both values travel with the pipeline.
//  - r_den == NUM: every pixel emits with weight NUM^2 on window[1][1], giving exact passthrough.
//    r_den == 2*NUM: every other index is emitted (2:1 decimation).
//  - An out-of-range r_den is undefined; verification excludes it.
//  - in_valid gaps are legal anywhere, including mid-row. Phase only advances on accepted pixels.
//  - Reset mid-frame: outputs clear in the reset cycle. No further output until the next frame start.
// TESTING
//  1 NUM_LOG2=2, r_den=5, 10x10 frame of constant 100
//    -> 64 outputs (8x8), all 100; out_x/out_y cover 0..7.
//  2 r_den=5, row 0 ramp in_pixel = 16*x, x = 0..9
//    -> row 0 outputs 0, 20, 40, 60, 80, 100, 120, 140.
//  3 Rounding: r_den=5, row 0 pixels (0, 0, 2, ...)
//    -> output 1 = 1; truncation would give 0.
//  4 Passthrough r_den=4, 6x4 frame of random pixels
//    -> 24 outputs equal the inputs, each 4 cycles after its input.
//    Then r_den=8 with a 10x10 frame -> 5x5 outputs = input pixels at even x,y.
//  5 Single pixel at (0,0) -> out_valid exactly 4 cycles later, out_x=0, out_y=0.
//    Change r_den mid-frame -> no effect until the next (0,0).
//  6 Assert reset at pixel (3,5) of a frame -> out_valid=0 immediately.
//    Pixels before the next (0,0) produce no output; the next frame is bit-exact.

Source files
------------

// File: rtl/scale_ratio_bilinear_if.sv
// Pixel-stream bundle for scale_ratio_bilinear: ratio/width configuration, raster input, scaled output.
interface scale_ratio_bilinear_if #(
  parameter int LUMA_BITS  = 8,
  parameter int COORD_BITS = 11,
  parameter int DEN_BITS   = 4
);
  logic [COORD_BITS-1:0] r_width;
  logic [DEN_BITS-1:0]   r_den;
  logic [LUMA_BITS-1:0]  in_pixel;
  logic                  in_valid;
  logic [COORD_BITS-1:0] in_x;
  logic [COORD_BITS-1:0] in_y;
  logic [LUMA_BITS-1:0]  out_pixel;
  logic                  out_valid;
  logic [COORD_BITS-1:0] out_x;
  logic [COORD_BITS-1:0] out_y;

  modport master (
    output r_width, r_den, in_pixel, in_valid, in_x, in_y,
    input  out_pixel, out_valid, out_x, out_y
  );

  modport slave (
    input  r_width, r_den, in_pixel, in_valid, in_x, in_y,
    output out_pixel, out_valid, out_x, out_y
  );
endinterface

// File: rtl/scale_ratio_bilinear.sv
// Streaming bilinear downscaler, ratio 2^NUM_LOG2 : r_den, built on a 2x2 line-buffered window
// feeding a 4-stage datapath (window/phase, weights, multiply, sum/round) with no backpressure.
module scale_ratio_bilinear #(
  parameter int LUMA_BITS       = 8,
  parameter int MAX_INPUT_WIDTH = 640,
  parameter int COORD_BITS      = 11,
  parameter int NUM_LOG2        = 2,
  parameter int DEN_BITS        = 4
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  scale_ratio_bilinear_if.slave bus
);
  localparam int NUM   = 1 << NUM_LOG2;
  localparam int PH_W  = NUM_LOG2 + 3;
  localparam int WT_W  = NUM_LOG2 + 1;
  localparam int W2_W  = 2 * NUM_LOG2 + 1;
  localparam int PR_W  = LUMA_BITS + W2_W;
  localparam int SUM_W = LUMA_BITS + 2 * NUM_LOG2 + 2;
  localparam int LB_AW = $clog2(MAX_INPUT_WIDTH);
  localparam logic signed [PH_W-1:0] NUM_S = PH_W'(NUM);
  localparam logic [COORD_BITS-1:0]  MAXW  = COORD_BITS'(MAX_INPUT_WIDTH);

  function automatic logic [WT_W-1:0] wt_left(input logic signed [PH_W-1:0] d);
    logic signed [PH_W-1:0] w;
    w = -d;
    return w[WT_W-1:0];
  endfunction

  function automatic logic [WT_W-1:0] wt_right(input logic signed [PH_W-1:0] d);
    logic signed [PH_W-1:0] w;
    w = NUM_S + d;
    return w[WT_W-1:0];
  endfunction

  function automatic logic [W2_W-1:0] wt_mul(input logic [WT_W-1:0] a, input logic [WT_W-1:0] b);
    return W2_W'(a) * W2_W'(b);
  endfunction

  // A zero weight must yield zero even when the tap holds stale or undefined data.
  function automatic logic [PR_W-1:0] gated_mul(input logic [LUMA_BITS-1:0] pix,
                                                input logic [W2_W-1:0]      w);
    if (w == '0) return '0;
    return PR_W'(pix) * PR_W'(w);
  endfunction

  function automatic logic [LUMA_BITS-1:0] round_sat(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] r;
    r = (s + SUM_W'(1 << (2 * NUM_LOG2 - 1))) >> (2 * NUM_LOG2);
    if (|r[SUM_W-1:LUMA_BITS]) return '1;
    return r[LUMA_BITS-1:0];
  endfunction

  logic                   accept, row_start, frame_start, proc;
  logic                   h_emit, v_emit, emit;
  logic [DEN_BITS-1:0]    den_q, den_eff;
  logic signed [PH_W-1:0] den_s, dh, dv, dh_d, dv_d, dv_use;
  logic signed [PH_W-1:0] dh_q, dv_q, dv_row_q;
  logic                   synced_q, v_emit_q;
  logic [COORD_BITS-1:0]  ox_q, oy_q, ox_d, oy_d;
  logic [LB_AW-1:0]       lb_idx;
  logic [LUMA_BITS-1:0]   line_q [MAX_INPUT_WIDTH];
  logic [LUMA_BITS-1:0]   top_pix, left_q, top_left_q;

  // Pixels past the configured row (or the line buffer) are not accepted at all.
  assign accept      = bus.in_valid && (bus.in_x < bus.r_width) && (bus.in_x < MAXW);
  assign row_start   = (bus.in_x == '0);
  assign frame_start = accept && row_start && (bus.in_y == '0);
  assign proc        = accept && (synced_q || frame_start);
  assign den_eff     = frame_start ? bus.r_den : den_q;
  assign den_s       = signed'(PH_W'(den_eff));
  assign lb_idx      = bus.in_x[LB_AW-1:0];
  assign top_pix     = line_q[lb_idx];

  always_comb begin
    dh     = row_start ? '0 : dh_q - NUM_S;
    dv     = (bus.in_y == '0) ? '0 : dv_q - NUM_S;
    h_emit = dh[PH_W-1] || (dh == '0);
    v_emit = row_start ? (dv[PH_W-1] || (dv == '0)) : v_emit_q;
    dv_use = row_start ? dv : dv_row_q;
    emit   = proc && h_emit && v_emit;
    dh_d   = h_emit ? dh + den_s : dh;
    dv_d   = (dv[PH_W-1] || (dv == '0)) ? dv + den_s : dv;
    ox_d   = row_start ? '0 : ox_q + COORD_BITS'(1);
    oy_d   = !row_start ? oy_q : ((bus.in_y == '0) ? '0 : oy_q + COORD_BITS'(1));
  end

  logic                   vld_p1, vld_p2, vld_p3;
  logic [LUMA_BITS-1:0]   win_p1 [4];
  logic [LUMA_BITS-1:0]   win_p2 [4];
  logic signed [PH_W-1:0] dh_p1, dv_p1;
  logic [W2_W-1:0]        w2_p2 [4];
  logic [PR_W-1:0]        prod_p3 [4];
  logic [COORD_BITS-1:0]  ox_p1, oy_p1, ox_p2, oy_p2, ox_p3, oy_p3;
  logic [SUM_W-1:0]       sum_s;
  logic [LUMA_BITS-1:0]   out_pixel_q;
  logic                   out_valid_q;
  logic [COORD_BITS-1:0]  out_x_q, out_y_q;

  assign sum_s = SUM_W'(prod_p3[0]) + SUM_W'(prod_p3[1]) + SUM_W'(prod_p3[2]) + SUM_W'(prod_p3[3]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      synced_q    <= 1'b0;
      den_q       <= '0;
      dh_q        <= '0;
      dv_q        <= '0;
      dv_row_q    <= '0;
      v_emit_q    <= 1'b0;
      ox_q        <= '0;
      oy_q        <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      vld_p3      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      if (frame_start) begin
        synced_q <= 1'b1;
        den_q    <= bus.r_den;
      end
      if (proc) begin
        dh_q <= dh_d;
        if (row_start) begin
          dv_q     <= dv_d;
          dv_row_q <= dv;
          v_emit_q <= v_emit;
        end
      end
      if (emit) begin
        ox_q <= ox_d;
        oy_q <= oy_d;
      end
      vld_p1      <= emit;
      vld_p2      <= vld_p1;
      vld_p3      <= vld_p2;
      out_valid_q <= vld_p3;
      // S4: sum, round, saturate
      if (vld_p3) begin
        out_pixel_q <= round_sat(sum_s);
        out_x_q     <= ox_p3;
        out_y_q     <= oy_p3;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (proc) begin
      line_q[lb_idx] <= bus.in_pixel;
      left_q         <= bus.in_pixel;
      top_left_q     <= top_pix;
    end
    // S1: window [prev row][prev col], [prev row][cur], [cur row][prev col], [cur][cur]
    if (emit) begin
      win_p1[0] <= top_left_q;
      win_p1[1] <= top_pix;
      win_p1[2] <= left_q;
      win_p1[3] <= bus.in_pixel;
      dh_p1     <= dh;
      dv_p1     <= dv_use;
      ox_p1     <= ox_d;
      oy_p1     <= oy_d;
    end
    // S2: separable weight products
    if (vld_p1) begin
      w2_p2[0] <= wt_mul(wt_left(dv_p1),  wt_left(dh_p1));
      w2_p2[1] <= wt_mul(wt_left(dv_p1),  wt_right(dh_p1));
      w2_p2[2] <= wt_mul(wt_right(dv_p1), wt_left(dh_p1));
      w2_p2[3] <= wt_mul(wt_right(dv_p1), wt_right(dh_p1));
      win_p2   <= win_p1;
      ox_p2    <= ox_p1;
      oy_p2    <= oy_p1;
    end
    // S3: multiply
    if (vld_p2) begin
      for (int k = 0; k < 4; k++) prod_p3[k] <= gated_mul(win_p2[k], w2_p2[k]);
      ox_p3 <= ox_p2;
      oy_p3 <= oy_p2;
    end
  end

  assign bus.out_pixel = out_pixel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
endmodule
